// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Round-robin arbiter that shares the single write port of the 64-bit x 32
// register file between two writeback sources: A (ALU) and B (load).
// The winning write is registered one cycle before it reaches the file.
// Writes to x0 are accepted but never assert the file's write enable.
// A saturating counter records the cycles in which both sources contended.
//
// Handshake: a transfer happens on a rising edge where x_valid & x_ready.
// A requester holds valid/rd/data stable until it sees ready. Ready may
// depend combinationally on valid, but valid must never depend on ready.
// At most one ready is high in any cycle, and both are low while rf_hold
// is 1 or while reset is asserted.
module regfile_write_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  a_valid,
   input  logic [ADDR_WIDTH-1:0] a_rd,
   input  logic [DATA_WIDTH-1:0] a_data,
   output logic                  a_ready,
   input  logic                  b_valid,
   input  logic [ADDR_WIDTH-1:0] b_rd,
   input  logic [DATA_WIDTH-1:0] b_data,
   output logic                  b_ready,
   input  logic                  rf_hold,
   output logic [ADDR_WIDTH-1:0] rf_rd,
   output logic                  rf_reg_write,
   output logic [DATA_WIDTH-1:0] rf_write_data,
   output logic [CNT_WIDTH-1:0]  conflict_count,
   output logic                  prio
);

   // Priority state: 0 favours A, 1 favours B on contention.
   logic                  r_prio;
   logic [ADDR_WIDTH-1:0] r_rf_rd;
   logic                  r_rf_reg_write;
   logic [DATA_WIDTH-1:0] r_rf_write_data;
   logic [CNT_WIDTH-1:0]  r_conflict_count;

   logic                  w_a_grant;
   logic                  w_b_grant;
   logic                  w_contend;
   logic                  w_cnt_full;

   // Grant decode: a lone requester wins; on contention prio picks the winner.
   // Reset gating keeps both readies low for the whole reset interval.
   always_comb begin
      w_a_grant = 1'b0;
      w_b_grant = 1'b0;
      if (reset && !rf_hold) begin
         w_a_grant = a_valid && (!b_valid || !r_prio);
         w_b_grant = b_valid && (!a_valid ||  r_prio);
      end
   end

   assign w_contend  = a_valid && b_valid && !rf_hold;
   assign w_cnt_full = (r_conflict_count == {CNT_WIDTH{1'b1}});

   // Round-robin pointer: after any transfer, point at the loser.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prio <= 1'b0;
      end else if (w_a_grant) begin
         r_prio <= 1'b1;
      end else if (w_b_grant) begin
         r_prio <= 1'b0;
      end
   end

   // Output register toward the register file; x0 writes never enable it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rf_rd         <= '0;
         r_rf_reg_write  <= 1'b0;
         r_rf_write_data <= '0;
      end else if (w_a_grant) begin
         r_rf_rd         <= a_rd;
         r_rf_reg_write  <= (a_rd != '0);
         r_rf_write_data <= a_data;
      end else if (w_b_grant) begin
         r_rf_rd         <= b_rd;
         r_rf_reg_write  <= (b_rd != '0);
         r_rf_write_data <= b_data;
      end else begin
         r_rf_reg_write  <= 1'b0;
      end
   end

   // Saturating contention counter, cleared only by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_conflict_count <= '0;
      end else if (w_contend && !w_cnt_full) begin
         r_conflict_count <= r_conflict_count + CNT_WIDTH'(1);
      end
   end

   assign a_ready        = w_a_grant;
   assign b_ready        = w_b_grant;
   assign rf_rd          = r_rf_rd;
   assign rf_reg_write   = r_rf_reg_write;
   assign rf_write_data  = r_rf_write_data;
   assign conflict_count = r_conflict_count;
   assign prio           = r_prio;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed vectors with hand-computed
// grants; accepted non-x0 writes are queued and matched against the
// register-file port by an independent monitor.
module tb_regfile_write_arbiter;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int CW = 16;

  logic          clk;
  logic          reset;
  logic          a_valid, b_valid, rf_hold;
  logic [AW-1:0] a_rd, b_rd;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready;
  logic [AW-1:0] rf_rd;
  logic          rf_reg_write;
  logic [DW-1:0] rf_write_data;
  logic [CW-1:0] conflict_count;
  logic          prio;

  int n_checks = 0;
  int n_pass   = 0;

  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0]    rf_model[32];

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .rf_hold(rf_hold), .rf_rd(rf_rd), .rf_reg_write(rf_reg_write),
    .rf_write_data(rf_write_data), .conflict_count(conflict_count), .prio(prio)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference register file fed by the DUT write port
  always @(posedge clk) begin
    if (rf_reg_write) rf_model[rf_rd] <= rf_write_data;
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // monitor: every register-file write must match the oldest expected write
  always @(negedge clk) begin
    if (reset && rf_reg_write) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write actual=rd%0d/%0h required=none", rf_rd, rf_write_data);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        check("wr_rd", DW'(rf_rd), DW'(e[AW+DW-1:DW]));
        check("wr_data", rf_write_data, e[DW-1:0]);
      end
    end
  end

  // driver: apply one cycle of inputs, check hand-computed readies,
  // queue accepted non-x0 writes, then advance to the next falling edge
  task automatic step(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                      input logic bv, input logic [AW-1:0] brd, input logic [DW-1:0] bd,
                      input logic hold, input logic exp_a, input logic exp_b, input string name);
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    rf_hold = hold;
    #1;
    check({name, "_a_ready"}, DW'(a_ready), DW'(exp_a));
    check({name, "_b_ready"}, DW'(b_ready), DW'(exp_b));
    if (exp_a && ard != 0) exp_q.push_back({ard, ad});
    if (exp_b && brd != 0) exp_q.push_back({brd, bd});
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
    reset = 1'b0;
    a_valid = 1'b1; a_rd = 5'd3; a_data = 64'hA;
    b_valid = 1'b1; b_rd = 5'd9; b_data = 64'hB;
    rf_hold = 1'b0;

    // reset held with both requesters valid
    @(negedge clk); @(negedge clk);
    #2;
    check("rst_a_ready", DW'(a_ready), 0);
    check("rst_b_ready", DW'(b_ready), 0);
    check("rst_rf_rd", DW'(rf_rd), 0);
    check("rst_rf_reg_write", DW'(rf_reg_write), 0);
    check("rst_rf_write_data", rf_write_data, 0);
    check("rst_conflict_count", DW'(conflict_count), 0);
    check("rst_prio", DW'(prio), 0);
    @(negedge clk);
    reset = 1'b1;

    // contention: first edge grants A, then strict alternation
    step(1, 3, 64'hA, 1, 9, 64'hB, 0, 1, 0, "cont0");
    step(1, 3, 64'hA, 1, 9, 64'hB, 0, 0, 1, "cont1");
    step(1, 3, 64'hA, 1, 9, 64'hB, 0, 1, 0, "cont2");
    step(1, 3, 64'hA, 1, 9, 64'hB, 0, 0, 1, "cont3");
    check("cont_count", DW'(conflict_count), 4);

    // single requester A -> register 2 holds 1 two edges later
    step(1, 2, 64'h1, 0, 0, 0, 0, 1, 0, "single");
    idle();
    check("rf_reg2", rf_model[2], 64'h1);

    // x0 write from B is accepted but not issued; prio moves back to A
    step(0, 0, 0, 1, 0, 64'hFF, 0, 0, 1, "x0");
    step(1, 4, 64'h44, 1, 5, 64'h55, 0, 1, 0, "after_x0");
    idle();
    check("rf_reg0", rf_model[0], 0);
    check("x0_count", DW'(conflict_count), 5);

    // hold for 3 cycles with contention: nothing accepted, count frozen
    step(1, 6, 64'h66, 1, 7, 64'h77, 1, 0, 0, "hold0");
    step(1, 6, 64'h66, 1, 7, 64'h77, 1, 0, 0, "hold1");
    step(1, 6, 64'h66, 1, 7, 64'h77, 1, 0, 0, "hold2");
    check("hold_count", DW'(conflict_count), 5);
    check("hold_no_write", DW'(rf_reg_write), 0);
    step(1, 6, 64'h66, 1, 7, 64'h77, 0, 0, 1, "resume0");
    step(1, 6, 64'h66, 0, 0, 0, 0, 1, 0, "resume1");
    check("resume_count", DW'(conflict_count), 6);

    // a hold pulse does not cancel the write already registered
    step(1, 8, 64'h88, 0, 0, 0, 0, 1, 0, "pre_hold");
    step(1, 10, 64'hAA, 0, 0, 0, 1, 0, 0, "pulse");
    step(1, 10, 64'hAA, 0, 0, 0, 0, 1, 0, "post_hold");
    idle();
    idle();
    check("rf_reg8", rf_model[8], 64'h88);
    check("rf_reg10", rf_model[10], 64'hAA);
    check("queue_drained", DW'(exp_q.size()), 0);

    // saturation: x0 contention on both sides so nothing is written
    a_valid = 1'b1; a_rd = 5'd0; b_valid = 1'b1; b_rd = 5'd0; rf_hold = 1'b0;
    for (int i = 0; i < 32'h10000; i++) @(negedge clk);
    check("sat_count", DW'(conflict_count), 64'hFFFF);
    for (int i = 0; i < 5; i++) @(negedge clk);
    check("sat_hold", DW'(conflict_count), 64'hFFFF);

    // async reset mid-cycle clears outputs without a clock edge
    step(1, 11, 64'hBB, 0, 0, 0, 0, 1, 0, "pre_rst");
    check("pre_rst_rd", DW'(rf_rd), 11);
    #2;
    reset = 1'b0;
    #1;
    check("arst_rf_rd", DW'(rf_rd), 0);
    check("arst_rf_reg_write", DW'(rf_reg_write), 0);
    check("arst_rf_write_data", rf_write_data, 0);
    check("arst_count", DW'(conflict_count), 0);
    check("arst_prio", DW'(prio), 0);
    check("arst_a_ready", DW'(a_ready), 0);
    check("final_queue", DW'(exp_q.size()), 0);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
